// File: rtl/prog_mem_ctl.sv
// rtl/prog_mem_ctl.sv - program memory with registered fetch, direct write and streaming bulk load
module prog_mem_ctl #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              fetch_en,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  input  logic              we,
  input  logic [DATA_W-1:0] data,
  input  logic              load_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              busy,
  output logic              load_done,
  output logic [ADDR_W:0]   load_count
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W:0]     load_count_q, load_count_d;
  logic [DATA_W-1:0]   out_q, out_d;
  logic                out_valid_q, out_valid_d;
  logic                ld_ready_q, ld_ready_d;
  logic                busy_q, busy_d;
  logic                load_done_q, load_done_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic                addr_ok;
  logic [DATA_W-1:0]   rd_word;

  assign addr_ok = ({1'b0, addr} < DEPTH_L);
  assign rd_word = addr_ok ? mem_q[addr] : '0;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    load_count_d = load_count_q;
    out_d        = out_q;
    out_valid_d  = 1'b0;
    wr_en        = 1'b0;
    wr_addr      = addr;
    wr_data      = data;

    case (state_q)
      LOAD: begin
        if (ld_valid && ld_ready_q) begin
          wr_en        = 1'b1;
          wr_addr      = ptr_q;
          wr_data      = ld_data;
          ptr_d        = ptr_q + 1'b1;
          load_count_d = load_count_q + 1'b1;
          if (ld_last || ptr_q == LAST_PTR) state_d = DONE;
        end
      end
      default: begin
        // IDLE and DONE share the fetch / direct-write port; only IDLE can start a load
        if (state_q == IDLE && load_start) begin
          state_d      = LOAD;
          ptr_d        = '0;
          load_count_d = '0;
        end else begin
          if (state_q != IDLE) state_d = IDLE;
          wr_en = we && addr_ok;
        end
        if (fetch_en) begin
          out_d       = rd_word;
          out_valid_d = 1'b1;
        end
      end
    endcase

    ld_ready_d  = (state_d == LOAD);
    busy_d      = (state_d == LOAD);
    load_done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      load_count_q <= '0;
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      ld_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      load_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      load_count_q <= load_count_d;
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      ld_ready_q   <= ld_ready_d;
      busy_q       <= busy_d;
      load_done_q  <= load_done_d;
    end
  end

  // Storage is deliberately never cleared so a reset keeps the loaded program
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem_q[wr_addr] <= wr_data;
  end

  assign out        = out_q;
  assign out_valid  = out_valid_q;
  assign ld_ready   = ld_ready_q;
  assign busy       = busy_q;
  assign load_done  = load_done_q;
  assign load_count = load_count_q;

endmodule

// File: tb/tb_prog_mem_ctl.sv
// tb/tb_prog_mem_ctl.sv - directed-vector bench for prog_mem_ctl (DEPTH=16 and DEPTH=12 instances)
module tb_prog_mem_ctl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] addr;
  logic       fetch_en;
  logic       we;
  logic [3:0] data;
  logic       load_start;
  logic       ld_valid;
  logic [3:0] ld_data;
  logic       ld_last;

  logic [3:0] out, b_out;
  logic       out_valid, b_out_valid;
  logic       ld_ready, b_ld_ready;
  logic       busy, b_busy;
  logic       load_done, b_load_done;
  logic [4:0] load_count, b_load_count;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  prog_mem_ctl #(.DATA_W(4), .ADDR_W(4), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .addr(addr), .fetch_en(fetch_en), .out(out), .out_valid(out_valid),
    .we(we), .data(data), .load_start(load_start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_last(ld_last), .ld_ready(ld_ready), .busy(busy), .load_done(load_done),
    .load_count(load_count)
  );

  prog_mem_ctl #(.DATA_W(4), .ADDR_W(4), .DEPTH(12)) dut_b (
    .clk(clk), .rst(rst), .addr(addr), .fetch_en(fetch_en), .out(b_out), .out_valid(b_out_valid),
    .we(we), .data(data), .load_start(load_start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_last(ld_last), .ld_ready(b_ld_ready), .busy(b_busy), .load_done(b_load_done),
    .load_count(b_load_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fetch_en = 0; we = 0; load_start = 0; ld_valid = 0; ld_last = 0;
  endtask

  // Fetch one word; the registered result is visible after the edge
  task automatic fetch(input logic [3:0] a);
    idle_inputs(); addr = a; fetch_en = 1;
    tick();
    fetch_en = 0;
  endtask

  function automatic logic [3:0] pat(input int i);
    return 4'((i * 3 + 1) & 15);
  endfunction

  task automatic test_reset();
    idle_inputs(); addr = 0; data = 0; ld_data = 0; rst = 1;
    tick(); tick();
    rst = 0;
    vecs++; if (out !== 4'h0) begin errs++; $display("FAIL reset_out got=%h exp=0", out); end
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    vecs++; if (ld_ready !== 1'b0) begin errs++; $display("FAIL reset_ld_ready got=%b exp=0", ld_ready); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b exp=0", busy); end
    vecs++; if (load_done !== 1'b0) begin errs++; $display("FAIL reset_load_done got=%b exp=0", load_done); end
    vecs++; if (load_count !== 5'd0) begin errs++; $display("FAIL reset_load_count got=%0d exp=0", load_count); end
  endtask

  task automatic test_direct_rw();
    idle_inputs(); we = 1; addr = 3; data = 4'h5;
    tick();
    fetch(4'd3);
    vecs++; if (out !== 4'h5) begin errs++; $display("FAIL direct_out got=%h exp=5", out); end
    vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL direct_valid got=%b exp=1", out_valid); end
    idle_inputs(); tick();
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL direct_valid_drop got=%b exp=0", out_valid); end
    vecs++; if (out !== 4'h5) begin errs++; $display("FAIL direct_out_hold got=%h exp=5", out); end
  endtask

  task automatic test_read_first();
    idle_inputs(); we = 1; data = 4'hA; fetch_en = 1; addr = 3;
    tick();
    vecs++; if (out !== 4'h5) begin errs++; $display("FAIL read_first_old got=%h exp=5", out); end
    fetch(4'd3);
    vecs++; if (out !== 4'hA) begin errs++; $display("FAIL read_first_new got=%h exp=a", out); end
  endtask

  task automatic test_short_load();
    idle_inputs(); load_start = 1;
    tick();
    load_start = 0;
    vecs++; if (ld_ready !== 1'b1 || busy !== 1'b1) begin errs++; $display("FAIL short_ready got=%b/%b exp=1/1", ld_ready, busy); end
    for (int i = 1; i <= 3; i++) begin
      ld_valid = 1; ld_data = 4'(i); ld_last = (i == 3);
      tick();
    end
    idle_inputs();
    vecs++; if (load_done !== 1'b1) begin errs++; $display("FAIL short_done got=%b exp=1", load_done); end
    vecs++; if (ld_ready !== 1'b0) begin errs++; $display("FAIL short_ready_drop got=%b exp=0", ld_ready); end
    vecs++; if (load_count !== 5'd3) begin errs++; $display("FAIL short_count got=%0d exp=3", load_count); end
    tick();
    vecs++; if (load_done !== 1'b0) begin errs++; $display("FAIL short_done_pulse got=%b exp=0", load_done); end
    for (int i = 0; i < 4; i++) begin
      fetch(4'(i));
      vecs++;
      if (out !== ((i == 3) ? 4'hA : 4'(i + 1))) begin
        errs++; $display("FAIL short_fetch%0d got=%h exp=%h", i, out, (i == 3) ? 4'hA : 4'(i + 1));
      end
    end
  endtask

  task automatic test_backpressure_full();
    idle_inputs(); load_start = 1;
    tick();
    load_start = 0;
    for (int i = 0; i < 17; i++) begin
      ld_valid = 1; ld_data = (i == 16) ? 4'hB : pat(i);
      tick();
      ld_valid = 0;
      if (i == 14) begin
        vecs++; if (ld_ready !== 1'b1) begin errs++; $display("FAIL full_ready15 got=%b exp=1", ld_ready); end
      end
      if (i == 15) begin
        vecs++; if (ld_ready !== 1'b0) begin errs++; $display("FAIL full_ready_drop got=%b exp=0", ld_ready); end
        vecs++; if (load_done !== 1'b1) begin errs++; $display("FAIL full_done got=%b exp=1", load_done); end
      end
      tick();
    end
    vecs++; if (load_count !== 5'd16) begin errs++; $display("FAIL full_count got=%0d exp=16", load_count); end
    vecs++; if (b_load_count !== 5'd12) begin errs++; $display("FAIL full_count_d12 got=%0d exp=12", b_load_count); end
    for (int i = 0; i < 16; i++) begin
      fetch(4'(i));
      vecs++; if (out !== pat(i)) begin errs++; $display("FAIL full_fetch%0d got=%h exp=%h", i, out, pat(i)); end
    end
  endtask

  task automatic test_ignored_in_load();
    logic [3:0] held;
    held = out;
    idle_inputs(); load_start = 1;
    tick();
    idle_inputs(); ld_valid = 1; ld_data = 4'h9;
    tick();
    idle_inputs(); we = 1; addr = 5; data = 4'hF; fetch_en = 1;
    tick();
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL load_fetch_valid got=%b exp=0", out_valid); end
    vecs++; if (out !== held) begin errs++; $display("FAIL load_out_hold got=%h exp=%h", out, held); end
    vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL load_busy got=%b exp=1", busy); end
    idle_inputs(); ld_valid = 1; ld_last = 1; ld_data = 4'h8;
    tick();
    idle_inputs(); tick();
    fetch(4'd5);
    vecs++; if (out !== pat(5)) begin errs++; $display("FAIL load_we_ignored got=%h exp=%h", out, pat(5)); end
    fetch(4'd1);
    vecs++; if (out !== 4'h8) begin errs++; $display("FAIL load_word1 got=%h exp=8", out); end
  endtask

  task automatic test_reset_mid_load_and_depth();
    idle_inputs(); load_start = 1;
    tick();
    idle_inputs();
    ld_valid = 1; ld_data = 4'hC; tick();
    ld_valid = 1; ld_data = 4'hD; tick();
    idle_inputs(); rst = 1;
    tick();
    rst = 0;
    vecs++; if (busy !== 1'b0 || ld_ready !== 1'b0) begin errs++; $display("FAIL midrst_idle got=%b/%b exp=0/0", busy, ld_ready); end
    vecs++; if (load_count !== 5'd0) begin errs++; $display("FAIL midrst_count got=%0d exp=0", load_count); end
    tick();
    vecs++; if (load_done !== 1'b0) begin errs++; $display("FAIL midrst_done got=%b exp=0", load_done); end
    fetch(4'd0);
    vecs++; if (out !== 4'hC) begin errs++; $display("FAIL midrst_word0 got=%h exp=c", out); end
    fetch(4'd1);
    vecs++; if (out !== 4'hD) begin errs++; $display("FAIL midrst_word1 got=%h exp=d", out); end
    fetch(4'd2);
    vecs++; if (out !== pat(2)) begin errs++; $display("FAIL midrst_word2 got=%h exp=%h", out, pat(2)); end
    idle_inputs(); we = 1; addr = 13; data = 4'h7;
    tick();
    fetch(4'd13);
    vecs++; if (b_out !== 4'h0) begin errs++; $display("FAIL d12_oob_read got=%h exp=0", b_out); end
    vecs++; if (b_out_valid !== 1'b1) begin errs++; $display("FAIL d12_oob_valid got=%b exp=1", b_out_valid); end
    vecs++; if (out !== 4'h7) begin errs++; $display("FAIL d16_addr13 got=%h exp=7", out); end
    fetch(4'd11);
    vecs++; if (b_out !== pat(11)) begin errs++; $display("FAIL d12_last_word got=%h exp=%h", b_out, pat(11)); end
  endtask

  initial begin
    rst = 1;
    test_reset();
    test_direct_rw();
    test_read_first();
    test_short_load();
    test_backpressure_full();
    test_ignored_in_load();
    test_reset_mid_load_and_depth();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
